// File: rtl/id_ex_control_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_defs
// Description : Shared constants for the ID/EX control path: primary opcodes,
//               the 2-bit ALUOpF encoding handed to ALU_Control, and the funct
//               codes synthesized for I-type logic/compare instructions.
//               Also defines the bundled control-bit vector carried in ID/EX.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOpF encoding understood by ALU_Control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NOP   = 2'b11;

  // Funct codes synthesized for I-type ops that reuse R-type ALU functions
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_NONE = 6'b000000;

  // Main control bits as one bundle so bubble/hold handling stays uniform
  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
    logic branch;
    logic branch_ne;
    logic jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage : mips_defs
`default_nettype wire

// File: rtl/id_ex_control_main_decoder.sv
`default_nettype none
// ============================================================================
// Module      : main_decoder
// Description : Purely combinational main decoder. Maps the primary opcode
//               (and funct for R-type) onto the control bits, ALUOpF, the
//               funct forwarded to ALU_Control, and an illegal-opcode flag.
// Ports       : i_opcode    - instr[31:26]
//               i_funct     - instr[5:0]
//               o_reg_dst .. o_jump - main control bits
//               o_aluop     - ALUOpF (00 add, 01 sub, 10 funct, 11 no-op)
//               o_funct     - funct for ALU_Control (000000 when unused)
//               o_illegal   - opcode not recognised
// Revision    : 1.0 - initial release
// ============================================================================
module main_decoder
  import mips_defs::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic       o_reg_dst,
  output logic       o_alu_src,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_branch,
  output logic       o_branch_ne,
  output logic       o_jump,
  output logic [1:0] o_aluop,
  output logic [5:0] o_funct,
  output logic       o_illegal
);

  ctrl_t w_ctrl;

  always_comb begin
    w_ctrl    = CTRL_NONE;
    o_aluop   = ALUOP_NOP;
    o_funct   = FUNCT_NONE;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_aluop          = ALUOP_FUNCT;
        o_funct          = i_funct;
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        o_aluop           = ALUOP_ADD;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        o_aluop          = ALUOP_ADD;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        o_aluop       = ALUOP_SUB;
        w_ctrl.branch = 1'b1;
      end
      OP_BNE: begin
        o_aluop          = ALUOP_SUB;
        w_ctrl.branch    = 1'b1;
        w_ctrl.branch_ne = 1'b1;
      end
      OP_ADDI: begin
        o_aluop          = ALUOP_ADD;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OP_ANDI: begin
        o_aluop          = ALUOP_FUNCT;
        o_funct          = FUNCT_AND;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OP_ORI: begin
        o_aluop          = ALUOP_FUNCT;
        o_funct          = FUNCT_OR;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OP_SLTI: begin
        o_aluop          = ALUOP_FUNCT;
        o_funct          = FUNCT_SLT;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OP_J: begin
        o_aluop     = ALUOP_NOP;
        w_ctrl.jump = 1'b1;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

  assign o_reg_dst    = w_ctrl.reg_dst;
  assign o_alu_src    = w_ctrl.alu_src;
  assign o_mem_read   = w_ctrl.mem_read;
  assign o_mem_write  = w_ctrl.mem_write;
  assign o_mem_to_reg = w_ctrl.mem_to_reg;
  assign o_reg_write  = w_ctrl.reg_write;
  assign o_branch     = w_ctrl.branch;
  assign o_branch_ne  = w_ctrl.branch_ne;
  assign o_jump       = w_ctrl.jump;

endmodule : main_decoder
`default_nettype wire

// File: rtl/id_ex_control.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_control
// Description : Decodes the IF/ID instruction and registers the ID/EX control
//               slice (control bits, ALUOpF/opcodeToALU, register specifiers,
//               valid/illegal). Handles flush, downstream hold and load-use
//               bubble insertion.
// Ports       : clk, rst_n      - clock, async active-low reset
//               instrID,validID - instruction in IF/ID and its valid flag
//               stallIn, flush  - downstream hold / kill slot entering EX
//               ALUOpF, opcodeToALU, RegDst..Jump - registered control
//               exRs, exRt, exRd - registered register specifiers
//               validEX, illegalEX - registered slot status
//               stallIF         - combinational: hold PC and IF/ID
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_control
  import mips_defs::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instrID,
  input  logic             validID,
  input  logic             stallIn,
  input  logic             flush,
  output logic [1:0]       ALUOpF,
  output logic [5:0]       opcodeToALU,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             Branch,
  output logic             BranchNE,
  output logic             Jump,
  output logic [REG_W-1:0] exRs,
  output logic [REG_W-1:0] exRt,
  output logic [REG_W-1:0] exRd,
  output logic             validEX,
  output logic             illegalEX,
  output logic             stallIF
);

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  ctrl_t      w_dec_ctrl;
  logic [1:0] w_dec_aluop;
  logic [5:0] w_dec_funct;
  logic       w_dec_illegal;

  main_decoder u_main_decoder (
    .i_opcode     (instrID[31:26]),
    .i_funct      (instrID[5:0]),
    .o_reg_dst    (w_dec_ctrl.reg_dst),
    .o_alu_src    (w_dec_ctrl.alu_src),
    .o_mem_read   (w_dec_ctrl.mem_read),
    .o_mem_write  (w_dec_ctrl.mem_write),
    .o_mem_to_reg (w_dec_ctrl.mem_to_reg),
    .o_reg_write  (w_dec_ctrl.reg_write),
    .o_branch     (w_dec_ctrl.branch),
    .o_branch_ne  (w_dec_ctrl.branch_ne),
    .o_jump       (w_dec_ctrl.jump),
    .o_aluop      (w_dec_aluop),
    .o_funct      (w_dec_funct),
    .o_illegal    (w_dec_illegal)
  );

  logic [REG_W-1:0] w_id_rs;
  logic [REG_W-1:0] w_id_rt;
  logic [REG_W-1:0] w_id_rd;

  assign w_id_rs = REG_W'(instrID[25:21]);
  assign w_id_rt = REG_W'(instrID[20:16]);
  assign w_id_rd = REG_W'(instrID[15:11]);

  // shamt is not needed by this stage
  logic w_unused_shamt;
  assign w_unused_shamt = ^instrID[10:6];

  // --------------------------------------------------------------------------
  // ID/EX registers
  // --------------------------------------------------------------------------
  ctrl_t            r_ctrl;
  logic [1:0]       r_aluop;
  logic [5:0]       r_funct;
  logic [REG_W-1:0] r_rs;
  logic [REG_W-1:0] r_rt;
  logic [REG_W-1:0] r_rd;
  logic             r_valid;
  logic             r_illegal;

  // --------------------------------------------------------------------------
  // Load-use hazard: a load in EX whose destination is read by the ID op.
  // rt is a source only for ops that do not take the immediate, plus sw
  // (which reads rt as the store data).
  // --------------------------------------------------------------------------
  logic w_rt_is_src;
  logic w_hazard;

  assign w_rt_is_src = ~w_dec_ctrl.alu_src | w_dec_ctrl.mem_write;

  assign w_hazard = r_valid && r_ctrl.mem_read && (r_rt != '0) && validID &&
                    ((r_rt == w_id_rs) || (w_rt_is_src && (r_rt == w_id_rt)));

  // A flush kills the ID op as well, so its hazard must not stall fetch
  assign stallIF = stallIn | (w_hazard & ~flush);

  // --------------------------------------------------------------------------
  // Next-state priority mux
  // --------------------------------------------------------------------------
  ctrl_t            w_nxt_ctrl;
  logic [1:0]       w_nxt_aluop;
  logic [5:0]       w_nxt_funct;
  logic [REG_W-1:0] w_nxt_rs;
  logic [REG_W-1:0] w_nxt_rt;
  logic [REG_W-1:0] w_nxt_rd;
  logic             w_nxt_valid;
  logic             w_nxt_illegal;

  always_comb begin
    // Default: bubble
    w_nxt_ctrl    = CTRL_NONE;
    w_nxt_aluop   = ALUOP_NOP;
    w_nxt_funct   = FUNCT_NONE;
    w_nxt_rs      = '0;
    w_nxt_rt      = '0;
    w_nxt_rd      = '0;
    w_nxt_valid   = 1'b0;
    w_nxt_illegal = 1'b0;
    if (flush) begin
      // bubble
    end else if (stallIn) begin
      w_nxt_ctrl    = r_ctrl;
      w_nxt_aluop   = r_aluop;
      w_nxt_funct   = r_funct;
      w_nxt_rs      = r_rs;
      w_nxt_rt      = r_rt;
      w_nxt_rd      = r_rd;
      w_nxt_valid   = r_valid;
      w_nxt_illegal = r_illegal;
    end else if (w_hazard || !validID) begin
      // bubble
    end else if (w_dec_illegal) begin
      // bubble tagged so the exception logic downstream can see it
      w_nxt_illegal = 1'b1;
    end else begin
      w_nxt_ctrl  = w_dec_ctrl;
      w_nxt_aluop = w_dec_aluop;
      w_nxt_funct = w_dec_funct;
      w_nxt_rs    = w_id_rs;
      w_nxt_rt    = w_id_rt;
      w_nxt_rd    = w_id_rd;
      w_nxt_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= CTRL_NONE;
      r_aluop   <= ALUOP_NOP;
      r_funct   <= FUNCT_NONE;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_ctrl    <= w_nxt_ctrl;
      r_aluop   <= w_nxt_aluop;
      r_funct   <= w_nxt_funct;
      r_rs      <= w_nxt_rs;
      r_rt      <= w_nxt_rt;
      r_rd      <= w_nxt_rd;
      r_valid   <= w_nxt_valid;
      r_illegal <= w_nxt_illegal;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ALUOpF      = r_aluop;
  assign opcodeToALU = r_funct;
  assign RegDst      = r_ctrl.reg_dst;
  assign ALUSrc      = r_ctrl.alu_src;
  assign MemRead     = r_ctrl.mem_read;
  assign MemWrite    = r_ctrl.mem_write;
  assign MemToReg    = r_ctrl.mem_to_reg;
  assign RegWrite    = r_ctrl.reg_write;
  assign Branch      = r_ctrl.branch;
  assign BranchNE    = r_ctrl.branch_ne;
  assign Jump        = r_ctrl.jump;
  assign exRs        = r_rs;
  assign exRt        = r_rt;
  assign exRd        = r_rd;
  assign validEX     = r_valid;
  assign illegalEX   = r_illegal;

endmodule : id_ex_control
`default_nettype wire

// File: tb/tb_id_ex_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_control
// Description : Directed self-checking bench for id_ex_control. Inputs are
//               driven 1 ns after a rising edge; registered outputs are
//               checked 1 ns after the following rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_control;

  localparam int REG_W = 5;

  logic             clk;
  logic             rst_n;
  logic [31:0]      instrID;
  logic             validID;
  logic             stallIn;
  logic             flush;
  logic [1:0]       ALUOpF;
  logic [5:0]       opcodeToALU;
  logic             RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite;
  logic             Branch, BranchNE, Jump;
  logic [REG_W-1:0] exRs, exRt, exRd;
  logic             validEX, illegalEX, stallIF;

  int r_checks   = 0;
  int r_failures = 0;

  // Hand-encoded instructions
  localparam logic [31:0] c_lw_8_9    = {6'b100011, 5'd9, 5'd8, 16'd0};
  localparam logic [31:0] c_lw_0_9    = {6'b100011, 5'd9, 5'd0, 16'd0};
  localparam logic [31:0] c_add_10_8  = {6'b000000, 5'd8, 5'd11, 5'd10, 5'd0, 6'b100000};
  localparam logic [31:0] c_add_10_0  = {6'b000000, 5'd0, 5'd11, 5'd10, 5'd0, 6'b100000};
  localparam logic [31:0] c_ori       = {6'b001101, 5'd1, 5'd2, 16'h00ff};
  localparam logic [31:0] c_beq       = {6'b000100, 5'd3, 5'd4, 16'd4};
  localparam logic [31:0] c_sw        = {6'b101011, 5'd5, 5'd6, 16'd8};
  localparam logic [31:0] c_addi      = {6'b001000, 5'd7, 5'd12, 16'd1};
  localparam logic [31:0] c_bad       = {6'b111111, 26'd0};

  id_ex_control #(.REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .instrID(instrID), .validID(validID),
    .stallIn(stallIn), .flush(flush), .ALUOpF(ALUOpF), .opcodeToALU(opcodeToALU),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .Branch(Branch), .BranchNE(BranchNE),
    .Jump(Jump), .exRs(exRs), .exRt(exRt), .exRd(exRd), .validEX(validEX),
    .illegalEX(illegalEX), .stallIF(stallIF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v);
    instrID = ins;
    validID = v;
  endtask

  initial begin
    rst_n = 1'b0; instrID = '0; validID = 1'b0; stallIn = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst_aluop", 32'(ALUOpF), 32'd3);
    chk("rst_valid", 32'(validEX), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // ---------------- decode sweep ----------------
    drive(c_add_10_8, 1'b1); tick();
    chk("radd_aluop", 32'(ALUOpF), 32'd2);
    chk("radd_funct", 32'(opcodeToALU), 32'h20);
    chk("radd_regdst_regwrite", {30'd0, RegDst, RegWrite}, 32'd3);
    chk("radd_valid_rd", {26'd0, validEX, exRd}, {26'd0, 1'b1, 5'd10});

    drive(c_ori, 1'b1); tick();
    chk("ori_aluop", 32'(ALUOpF), 32'd2);
    chk("ori_funct", 32'(opcodeToALU), 32'h25);
    chk("ori_alusrc_regwrite", {30'd0, ALUSrc, RegWrite}, 32'd3);

    drive(c_beq, 1'b1); tick();
    chk("beq_aluop", 32'(ALUOpF), 32'd1);
    chk("beq_branch_bne_rw", {29'd0, Branch, BranchNE, RegWrite}, 32'b100);

    drive(c_sw, 1'b1); tick();
    chk("sw_aluop", 32'(ALUOpF), 32'd0);
    chk("sw_memw_regw_alusrc", {29'd0, MemWrite, RegWrite, ALUSrc}, 32'b101);
    chk("sw_funct", 32'(opcodeToALU), 32'd0);

    // ---------------- load-use ----------------
    drive(c_lw_8_9, 1'b1); tick();
    chk("lw_memread_rt", {26'd0, MemRead, exRt}, {26'd0, 1'b1, 5'd8});
    drive(c_add_10_8, 1'b1); #1;
    chk("lu_stallif_hazard", 32'(stallIF), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(validEX), 32'd0);
    chk("lu_bubble_aluop", 32'(ALUOpF), 32'd3);
    chk("lu_stallif_clear", 32'(stallIF), 32'd0);
    tick();
    chk("lu_add_loaded", {26'd0, validEX, exRs}, {26'd0, 1'b1, 5'd8});
    chk("lu_add_aluop", 32'(ALUOpF), 32'd2);

    // load to $0 never creates a hazard
    drive(c_lw_0_9, 1'b1); tick();
    drive(c_add_10_0, 1'b1); #1;
    chk("lu0_no_stall", 32'(stallIF), 32'd0);
    tick();
    chk("lu0_add_loaded", {26'd0, validEX, exRs}, {26'd0, 1'b1, 5'd0});

    // ---------------- hold ----------------
    drive(c_addi, 1'b1); tick();
    drive(c_beq, 1'b1); stallIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_aluop", 32'(ALUOpF), 32'd0);
      chk("hold_rt_valid_alusrc", {25'd0, validEX, ALUSrc, exRt}, {25'd0, 1'b1, 1'b1, 5'd12});
      chk("hold_stallif", 32'(stallIF), 32'd1);
    end
    stallIn = 1'b0; tick();
    chk("hold_release_beq", {29'd0, ALUOpF, Branch}, {29'd0, 2'd1, 1'b1});

    // ---------------- flush vs stall vs hazard ----------------
    drive(c_lw_8_9, 1'b1); tick();
    drive(c_add_10_8, 1'b1); flush = 1'b1; #1;
    chk("flush_masks_hazard", 32'(stallIF), 32'd0);
    stallIn = 1'b1; #1;
    chk("flush_stallin_stallif", 32'(stallIF), 32'd1);
    tick();
    chk("flush_bubble", {28'd0, validEX, MemRead, ALUOpF}, {28'd0, 1'b0, 1'b0, 2'd3});
    flush = 1'b0; stallIn = 1'b0;

    // ---------------- illegal opcode ----------------
    drive(c_bad, 1'b1); tick();
    chk("ill_flags", {30'd0, illegalEX, validEX}, 32'b10);
    chk("ill_aluop", 32'(ALUOpF), 32'd3);
    chk("ill_rw_mw", {30'd0, RegWrite, MemWrite}, 32'd0);

    // ---------------- invalid slot ----------------
    drive(c_add_10_8, 1'b0); tick();
    chk("inv_bubble", {28'd0, illegalEX, validEX, RegWrite, RegDst}, 32'd0);

    // ---------------- async reset with lw loaded ----------------
    drive(c_lw_8_9, 1'b1); tick();
    chk("prerst_memread", 32'(MemRead), 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("arst_aluop", 32'(ALUOpF), 32'd3);
    chk("arst_bits", {23'd0, RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, Branch, BranchNE, Jump}, 32'd0);
    chk("arst_valid_rt", {26'd0, validEX, exRt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    drive(c_ori, 1'b1); tick();
    chk("postrst_load", {29'd0, validEX, ALUOpF}, {29'd0, 1'b1, 2'd2});

    $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
    $finish;
  end

endmodule : tb_id_ex_control
`default_nettype wire
